rob_queue: RTL and testbench
============================

Name: rob_queue

Overview:
- Parametrised reorder buffer for the out-of-order core. Holds in-flight instructions in a circular queue.
- Allocates one entry per cycle from the dispatch stage and accepts results from WB_PORTS writeback channels.
- Retires up to COMMIT_WIDTH completed entries per cycle, in program order, to the regfile commit channel.
- Reports the oldest faulting entry to the pipeline controller and is cleared by a flush.

Parameters:
ADDR_WIDTH, 4, entry index width; DEPTH = 2**ADDR_WIDTH
WB_PORTS, 2, number of writeback channels
COMMIT_WIDTH, 2, maximum entries retired per cycle (1 or 2)
EXC_WIDTH, 4, exception type width; value 0 = EXC_TYPE_NULL
EXC_IF, 4'h1, code reported for a misaligned PC

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear, from pipeline controller
dispatch_en  in  1  allocate request
dispatch_ready  out  1  entry free (count < DEPTH)
dispatch_id  out  ADDR_WIDTH  index the allocation receives (tail)
dispatch_reg_write_en  in  1  instruction writes GPR
dispatch_reg_write_addr  in  5  destination GPR
dispatch_exception_type  in  EXC_WIDTH  decode-time exception
dispatch_is_delayslot  in  1  delay-slot flag
dispatch_pc  in  32  instruction PC
wb_en  in  WB_PORTS  per-channel result valid
wb_id  in  WB_PORTS*ADDR_WIDTH  target entry per channel
wb_data  in  WB_PORTS*32  result per channel
wb_exception_type  in  WB_PORTS*EXC_WIDTH  execute-time exception
reg_commit_en  out  COMMIT_WIDTH  per-slot regfile write
reg_commit_addr  out  COMMIT_WIDTH*5  per-slot GPR
reg_commit_data  out  COMMIT_WIDTH*32  per-slot data
commit_id  out  COMMIT_WIDTH*ADDR_WIDTH  retired entry index, for regfile ref clear
exception_type_out  out  EXC_WIDTH  head exception, NULL when none
is_delayslot_out  out  1  head delay-slot flag
current_pc_out  out  32  head PC
count  out  ADDR_WIDTH+1  occupied entries

Behaviour:
- Reset (rst low, asynchronous): head = tail = count = 0; all valid and done bits clear.
  - Outputs during reset: dispatch_ready = 1, dispatch_id = 0, count = 0, reg_commit_en = 0.
  - exception_type_out = NULL. is_delayslot_out = 0 and current_pc_out = 0 (the head entry's fields are zero).
- Entry fields: valid, done, reg_write_en, reg_addr, data, exc, is_delayslot, pc.
- Dispatch:
  - Occurs when dispatch_en && dispatch_ready && !flush.
  - Writes the tail entry with valid = 1, done = 0 and all dispatch_* fields; tail increments.
  - dispatch_ready is derived from the registered count only. There is no same-cycle bypass from commit, so a full queue stays unready in its commit cycle.
- Writeback channel i:
  - Acts when wb_en[i] is set and entry wb_id[i] is valid.
  - Sets done and stores the data.
  - The entry's exc takes the wb exception only if the stored exc is NULL; the first fault is kept.
  - Writeback to an invalid entry is ignored.
  - If two channels target the same id in one cycle, the lower index wins.
  - A writeback landing in the same cycle as the entry's dispatch is ignored.
- Commit (combinational from registered state, visible in the same cycle):
  - Slot k (offset k from head) retires iff all earlier slots retire and entry head+k is valid, done, has exc == NULL and pc[1:0] == 0.
  - reg_commit_en[k] = retire_k && reg_write_en && !flush.
  - On the clock edge: valid is cleared for retired entries; head advances by the number retired; count = count + dispatched - retired.
- Exception:
  - Raised when the head is valid && done and either exc != NULL or pc[1:0] != 0.
  - exception_type_out = exc if exc != NULL, else EXC_IF. The stored exc has priority over EXC_IF.
  - No slot retires while an exception is raised. The head is held until flush.
  - A faulting entry in slot 1 stops retirement after slot 0 and is reported the next cycle.
  - is_delayslot_out and current_pc_out always reflect the head entry, whether or not an exception is raised.
- Flush:
  - Flush has priority over dispatch, writeback and retirement in the same cycle.
  - Next state: head = tail = count = 0, all valid clear.
- Wrap-around: pointers are ADDR_WIDTH bits and overflow naturally. Full is count == DEPTH; empty is count == 0.

Test Plan:
- Reset then dispatch 16 entries (ADDR_WIDTH = 4) with no writeback -> dispatch_ids 0..15; dispatch_ready drops after the 16th; count = 16.
- Entry 0 done (reg 5, data 0x1234) and entry 1 done (reg 6, data 0xABCD) -> same cycle reg_commit_en = 2'b11 with those addr/data; count drops by 2.
- Out-of-order writeback: entry 1 done before entry 0 -> no commit until entry 0 is done, then both retire in one cycle.
- Writeback with exception 4'h8 on the head entry at pc 0x80 -> exception_type_out = 8, current_pc_out = 0x80, reg_commit_en = 0 held; flush -> count = 0 next cycle, exception_type_out = NULL.
- Head pc 0x82 with no exception -> exception_type_out = EXC_IF; with a stored exc of 4'h8 -> 8 is reported.
- Fill to 15 and drain repeatedly past index 15 -> ids wrap 15 -> 0; data retires in order; count never exceeds 16.

Source files
------------

// File: rtl/rob_queue.sv
// rob_queue: circular reorder buffer with multi-port writeback, in-order multi-slot retire
// and head-of-queue fault reporting.
module rob_queue #(
    parameter int ADDR_WIDTH = 4,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int EXC_WIDTH = 4,
    parameter logic [EXC_WIDTH-1:0] EXC_IF = 4'h1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             dispatch_en,
    output logic                             dispatch_ready,
    output logic [ADDR_WIDTH-1:0]            dispatch_id,
    input  logic                             dispatch_reg_write_en,
    input  logic [4:0]                       dispatch_reg_write_addr,
    input  logic [EXC_WIDTH-1:0]             dispatch_exception_type,
    input  logic                             dispatch_is_delayslot,
    input  logic [31:0]                      dispatch_pc,
    input  logic [WB_PORTS-1:0]              wb_en,
    input  logic [WB_PORTS*ADDR_WIDTH-1:0]   wb_id,
    input  logic [WB_PORTS*32-1:0]           wb_data,
    input  logic [WB_PORTS*EXC_WIDTH-1:0]    wb_exception_type,
    output logic [COMMIT_WIDTH-1:0]          reg_commit_en,
    output logic [COMMIT_WIDTH*5-1:0]        reg_commit_addr,
    output logic [COMMIT_WIDTH*32-1:0]       reg_commit_data,
    output logic [COMMIT_WIDTH*ADDR_WIDTH-1:0] commit_id,
    output logic [EXC_WIDTH-1:0]             exception_type_out,
    output logic                             is_delayslot_out,
    output logic [31:0]                      current_pc_out,
    output logic [ADDR_WIDTH:0]              count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic                 reg_write_en;
        logic [4:0]           reg_addr;
        logic [31:0]          data;
        logic [EXC_WIDTH-1:0] exc;
        logic                 is_delayslot;
        logic [31:0]          pc;
    } entry_t;

    entry_t                ent [DEPTH];
    logic [DEPTH-1:0]      valid, done;
    logic [ADDR_WIDTH-1:0] head, tail;
    logic [ADDR_WIDTH-1:0] idx [COMMIT_WIDTH];
    logic [ADDR_WIDTH-1:0] wid [WB_PORTS];
    logic [COMMIT_WIDTH-1:0] retire;
    logic [ADDR_WIDTH:0]   n_ret;
    logic                  disp, head_fault, ok;

    assign dispatch_ready = count != (ADDR_WIDTH+1)'(DEPTH);
    assign dispatch_id = tail;
    assign disp = dispatch_en && dispatch_ready && !flush;
    assign head_fault = valid[head] && done[head] && (ent[head].exc != '0 || ent[head].pc[1:0] != 2'b00);
    assign exception_type_out = !head_fault ? '0 : ent[head].exc != '0 ? ent[head].exc : EXC_IF;
    assign is_delayslot_out = ent[head].is_delayslot;
    assign current_pc_out = ent[head].pc;

    always_comb begin
        for (int i = 0; i < WB_PORTS; i++) wid[i] = wb_id[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Retirement is a prefix: each slot needs every older slot to retire too.
    always_comb begin
        ok = 1'b1;
        n_ret = '0;
        retire = '0;
        reg_commit_en = '0;
        reg_commit_addr = '0;
        reg_commit_data = '0;
        commit_id = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            idx[k] = head + ADDR_WIDTH'(k);
            ok = ok && valid[idx[k]] && done[idx[k]] && ent[idx[k]].exc == '0 && ent[idx[k]].pc[1:0] == 2'b00;
            retire[k] = ok;
            n_ret = n_ret + (ADDR_WIDTH+1)'(ok);
            reg_commit_en[k] = ok && ent[idx[k]].reg_write_en && !flush;
            reg_commit_addr[k*5 +: 5] = ent[idx[k]].reg_addr;
            reg_commit_data[k*32 +: 32] = ent[idx[k]].data;
            commit_id[k*ADDR_WIDTH +: ADDR_WIDTH] = idx[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            done <= '0;
            ent <= '{default: '0};
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            done <= '0;
        end else begin
            // Highest channel first so the lowest-indexed channel's write lands last.
            for (int i = WB_PORTS - 1; i >= 0; i--) begin
                if (wb_en[i] && valid[wid[i]]) begin
                    done[wid[i]] <= 1'b1;
                    ent[wid[i]].data <= wb_data[i*32 +: 32];
                    ent[wid[i]].exc <= ent[wid[i]].exc == '0 ? wb_exception_type[i*EXC_WIDTH +: EXC_WIDTH] : ent[wid[i]].exc;
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (retire[k]) valid[idx[k]] <= 1'b0;
            end
            if (disp) begin
                valid[tail] <= 1'b1;
                done[tail] <= 1'b0;
                ent[tail] <= {dispatch_reg_write_en, dispatch_reg_write_addr, 32'h0,
                              dispatch_exception_type, dispatch_is_delayslot, dispatch_pc};
                tail <= tail + 1'b1;
            end
            head <= head + n_ret[ADDR_WIDTH-1:0];
            count <= count + (ADDR_WIDTH+1)'(disp) - n_ret;
        end
    end
endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue: directed stimulus for rob_queue checked every cycle against an
// in-order queue model, plus hand-computed literal expectations.
module tb_rob_queue;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, dispatch_en = 1'b0;
    logic        dre = 1'b0, dds = 1'b0;
    logic [4:0]  dra = '0;
    logic [3:0]  dexc = '0;
    logic [31:0] dpc = '0;
    logic [1:0]  wb_en = '0;
    logic [7:0]  wb_id = '0, wb_exc = '0;
    logic [63:0] wb_data = '0;
    logic        dispatch_ready, is_delayslot_out;
    logic [3:0]  dispatch_id, exception_type_out;
    logic [1:0]  reg_commit_en;
    logic [9:0]  reg_commit_addr;
    logic [63:0] reg_commit_data;
    logic [7:0]  commit_id;
    logic [31:0] current_pc_out;
    logic [4:0]  count;

    rob_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_ready(dispatch_ready), .dispatch_id(dispatch_id),
        .dispatch_reg_write_en(dre), .dispatch_reg_write_addr(dra),
        .dispatch_exception_type(dexc), .dispatch_is_delayslot(dds), .dispatch_pc(dpc),
        .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data), .wb_exception_type(wb_exc),
        .reg_commit_en(reg_commit_en), .reg_commit_addr(reg_commit_addr),
        .reg_commit_data(reg_commit_data), .commit_id(commit_id),
        .exception_type_out(exception_type_out), .is_delayslot_out(is_delayslot_out),
        .current_pc_out(current_pc_out), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          done;
        bit          rwe;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  exc;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          next_id = 0;
    logic [31:0] sh_pc[16];
    logic        sh_ds[16];
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit ent_ok(input ent_t e);
        return e.done && e.exc == 4'h0 && e.pc[1:0] == 2'b00;
    endfunction

    function automatic int model_nret();
        int n = 0;
        for (int k = 0; k < 2; k++)
            if (k < q.size() && n == k && ent_ok(q[k])) n++;
        return n;
    endfunction

    // Compare process: all outputs against the queue model on every falling edge.
    always @(negedge clk) begin
        int nr, hid;
        logic [3:0] ee;
        nr = model_nret();
        chk("count", 64'(count), 64'(q.size()));
        chk("dispatch_ready", 64'(dispatch_ready), 64'(q.size() < 16));
        chk("dispatch_id", 64'(dispatch_id), 64'(next_id));
        for (int k = 0; k < 2; k++) begin
            chk("reg_commit_en", 64'(reg_commit_en[k]), 64'((k < nr) ? (q[k].rwe && !flush) : 1'b0));
            if (k < nr) begin
                chk("commit_id", 64'(commit_id[k*4 +: 4]), 64'(q[k].id));
                if (q[k].rwe && !flush) begin
                    chk("reg_commit_addr", 64'(reg_commit_addr[k*5 +: 5]), 64'(q[k].addr));
                    chk("reg_commit_data", 64'(reg_commit_data[k*32 +: 32]), 64'(q[k].data));
                end
            end
        end
        ee = 4'h0;
        if (q.size() > 0)
            if (q[0].done && (q[0].exc != 4'h0 || q[0].pc[1:0] != 2'b00))
                ee = q[0].exc != 4'h0 ? q[0].exc : 4'h1;
        chk("exception_type_out", 64'(exception_type_out), 64'(ee));
        hid = q.size() > 0 ? q[0].id : next_id;
        chk("current_pc_out", 64'(current_pc_out), 64'(sh_pc[hid]));
        chk("is_delayslot_out", 64'(is_delayslot_out), 64'(sh_ds[hid]));
    end

    // Model update: writeback, then in-order retire, then append the new instruction.
    always @(posedge clk) begin
        int nr;
        bit dok;
        ent_t e;
        if (!rst) begin
            q.delete();
            next_id = 0;
            for (int i = 0; i < 16; i++) begin
                sh_pc[i] = '0;
                sh_ds[i] = 1'b0;
            end
        end else if (flush) begin
            q.delete();
            next_id = 0;
        end else begin
            nr = model_nret();
            dok = dispatch_en && q.size() < 16;
            for (int i = 0; i < 2; i++) begin
                if (wb_en[i] && !(i == 1 && wb_en[0] && wb_id[3:0] == wb_id[7:4])) begin
                    for (int j = 0; j < q.size(); j++) begin
                        if (q[j].id == int'(wb_id[i*4 +: 4])) begin
                            e = q[j];
                            e.done = 1'b1;
                            e.data = wb_data[i*32 +: 32];
                            if (e.exc == 4'h0) e.exc = wb_exc[i*4 +: 4];
                            q[j] = e;
                        end
                    end
                end
            end
            repeat (nr) void'(q.pop_front());
            if (dok) begin
                e.id = next_id;
                e.done = 1'b0;
                e.rwe = dre;
                e.addr = dra;
                e.data = '0;
                e.exc = dexc;
                e.pc = dpc;
                q.push_back(e);
                sh_pc[next_id] = dpc;
                sh_ds[next_id] = dds;
                next_id = (next_id + 1) % 16;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        dispatch_en = 1'b0;
        wb_en = '0;
        flush = 1'b0;
        dds = 1'b0;
        dexc = '0;
    endtask

    task automatic disp(input logic [4:0] a, input logic [31:0] pc, input logic [3:0] e, input logic ds);
        dispatch_en = 1'b1;
        dre = 1'b1;
        dra = a;
        dpc = pc;
        dexc = e;
        dds = ds;
    endtask

    task automatic wb(input int ch, input int id, input logic [31:0] d, input logic [3:0] e);
        wb_en[ch] = 1'b1;
        wb_id[ch*4 +: 4] = 4'(id);
        wb_data[ch*32 +: 32] = d;
        wb_exc[ch*4 +: 4] = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_ready", 64'(dispatch_ready), 64'(1));
        chk("lit_rst_count", 64'(count), 64'(0));
        chk("lit_rst_commit", 64'(reg_commit_en), 64'(0));
        chk("lit_rst_exc", 64'(exception_type_out), 64'(0));
        chk("lit_rst_pc", 64'(current_pc_out), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            disp(5'(i + 5), 32'h100 + 32'(4 * i), 4'h0, 1'b0);
            @(negedge clk);
            chk("lit_fill_id", 64'(dispatch_id), 64'(i));
            cyc();
        end
        disp(5'd1, 32'h200, 4'h0, 1'b0);
        wb(0, 0, 32'h1234, 4'h0);
        wb(1, 1, 32'hABCD, 4'h0);
        @(negedge clk);
        chk("lit_full_ready", 64'(dispatch_ready), 64'(0));
        chk("lit_full_count", 64'(count), 64'(16));
        cyc();
        disp(5'd1, 32'h200, 4'h0, 1'b0);
        @(negedge clk);
        chk("lit_pair_en", 64'(reg_commit_en), 64'(2'b11));
        chk("lit_pair_addr", 64'(reg_commit_addr), 64'({5'd6, 5'd5}));
        chk("lit_pair_data", reg_commit_data, {32'hABCD, 32'h1234});
        chk("lit_pair_ready", 64'(dispatch_ready), 64'(0));
        cyc();
        @(negedge clk);
        chk("lit_after_pair_count", 64'(count), 64'(14));
        cyc();
        wb(0, 3, 32'h33, 4'h0);
        cyc();
        wb(0, 2, 32'h22, 4'h0);
        @(negedge clk);
        chk("lit_ooo_hold", 64'(reg_commit_en), 64'(0));
        cyc();
        @(negedge clk);
        chk("lit_ooo_en", 64'(reg_commit_en), 64'(2'b11));
        chk("lit_ooo_data", reg_commit_data, {32'h33, 32'h22});
        cyc();
        wb(0, 4, 32'h44, 4'h0);
        wb(1, 4, 32'h99, 4'h8);
        cyc();
        @(negedge clk);
        chk("lit_conflict_en", 64'(reg_commit_en), 64'(2'b01));
        chk("lit_conflict_data", 64'(reg_commit_data[31:0]), 64'(32'h44));
        cyc();
        flush = 1'b1;
        disp(5'd1, 32'h300, 4'h0, 1'b0);
        cyc();
        @(negedge clk);
        chk("lit_flush_count", 64'(count), 64'(0));
        chk("lit_flush_id", 64'(dispatch_id), 64'(0));
        cyc();
        disp(5'd1, 32'h80, 4'h0, 1'b1);
        cyc();
        disp(5'd2, 32'h84, 4'h0, 1'b0);
        cyc();
        wb(0, 0, 32'h0, 4'h8);
        wb(1, 1, 32'h5, 4'h0);
        cyc();
        @(negedge clk);
        chk("lit_exc_type", 64'(exception_type_out), 64'(8));
        chk("lit_exc_pc", 64'(current_pc_out), 64'(32'h80));
        chk("lit_exc_ds", 64'(is_delayslot_out), 64'(1));
        chk("lit_exc_commit", 64'(reg_commit_en), 64'(0));
        cyc();
        wb(0, 0, 32'h7, 4'h3);
        cyc();
        @(negedge clk);
        chk("lit_exc_first_kept", 64'(exception_type_out), 64'(8));
        cyc();
        flush = 1'b1;
        cyc();
        @(negedge clk);
        chk("lit_exc_flush_count", 64'(count), 64'(0));
        chk("lit_exc_flush_type", 64'(exception_type_out), 64'(0));
        cyc();
        disp(5'd3, 32'h82, 4'h0, 1'b0);
        cyc();
        wb(0, 0, 32'h1, 4'h0);
        cyc();
        @(negedge clk);
        chk("lit_misalign_type", 64'(exception_type_out), 64'(1));
        chk("lit_misalign_pc", 64'(current_pc_out), 64'(32'h82));
        cyc();
        flush = 1'b1;
        cyc();
        disp(5'd3, 32'h82, 4'h8, 1'b0);
        cyc();
        wb(0, 0, 32'h1, 4'h0);
        cyc();
        @(negedge clk);
        chk("lit_exc_priority", 64'(exception_type_out), 64'(8));
        cyc();
        flush = 1'b1;
        cyc();
        disp(5'd4, 32'h0, 4'h0, 1'b0);
        cyc();
        disp(5'd5, 32'h6, 4'h0, 1'b0);
        cyc();
        wb(0, 0, 32'h11, 4'h0);
        wb(1, 1, 32'h22, 4'h0);
        cyc();
        @(negedge clk);
        chk("lit_slot1_fault_en", 64'(reg_commit_en), 64'(2'b01));
        chk("lit_slot1_fault_none", 64'(exception_type_out), 64'(0));
        cyc();
        @(negedge clk);
        chk("lit_slot1_fault_type", 64'(exception_type_out), 64'(1));
        chk("lit_slot1_fault_pc", 64'(current_pc_out), 64'(32'h6));
        cyc();
        flush = 1'b1;
        cyc();
        disp(5'd6, 32'h10, 4'h0, 1'b0);
        wb(0, 0, 32'h55, 4'h0);
        cyc();
        @(negedge clk);
        chk("lit_same_cycle_wb", 64'(reg_commit_en), 64'(0));
        cyc();
        wb(0, 0, 32'h66, 4'h0);
        cyc();
        @(negedge clk);
        chk("lit_late_wb_data", 64'(reg_commit_data[31:0]), 64'(32'h66));
        cyc();
        n = 0;
        repeat (3) begin
            while (q.size() < 15) begin
                disp(5'($urandom_range(31)), 32'(4 * n), 4'h0, 1'($urandom_range(1)));
                dre = 1'($urandom_range(1));
                n++;
                cyc();
            end
            @(negedge clk);
            chk("lit_wrap_count", 64'(count), 64'(15));
            cyc();
            for (int t = 0; t < 40 && q.size() > 0; t++) begin
                if (q.size() > 0 && !q[0].done) wb(0, q[0].id, $urandom, 4'h0);
                if (q.size() > 1 && !q[1].done) wb(1, q[1].id, $urandom, 4'h0);
                @(negedge clk);
                chk("lit_wrap_bound", 64'(count <= 5'd16), 64'(1));
                cyc();
            end
        end
        @(negedge clk);
        chk("lit_wrap_empty", 64'(count), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
